// File: rtl/fpaddsub_round_module.sv
// Purpose: round-to-nearest-even and IEEE754 pack stage after the FP add/sub normalizer.
// Latency: 2 cycles (round register, pack register), 1 beat/cycle throughput.
// Backpressure: valid/ready; IN_READY = ~v1 | ~v2 | OUT_READY, stalled payload held stable.
module fpaddsub_round_module #(
  parameter int EXP_W  = 8,
  parameter int FRAC_W = 23
) (
  input  logic                    CLK,
  input  logic                    RST_N,
  input  logic                    IN_VALID,
  output logic                    IN_READY,
  input  logic                    IN_S,
  input  logic [EXP_W-1:0]        IN_E,
  input  logic [FRAC_W-1:0]       IN_F,
  input  logic [2:0]              IN_GRS,
  input  logic [1:0]              IN_SPEC,
  output logic                    OUT_VALID,
  input  logic                    OUT_READY,
  output logic [EXP_W+FRAC_W:0]   OUT_Z,
  output logic                    OUT_OVF,
  output logic                    OUT_INX
);

  localparam int SUM_W = EXP_W + FRAC_W;

  localparam logic [1:0] SPEC_NORM = 2'b00;
  localparam logic [1:0] SPEC_ZERO = 2'b01;
  localparam logic [1:0] SPEC_INF  = 2'b10;

  localparam logic [EXP_W-1:0]       EXP_MAX   = {EXP_W{1'b1}};
  localparam logic [EXP_W+FRAC_W:0]  QNAN_WORD = {1'b0, EXP_MAX, 1'b1, {(FRAC_W-1){1'b0}}};

  // stage 1 state
  logic              v1;
  logic              s1;
  logic [SUM_W-1:0]  sum1;
  logic [1:0]        spec1;
  logic              inx1;
  logic              emax1;

  // stage 2 valid (payload lives directly in the output registers)
  logic              v2;

  logic              load1;
  logic              load2;
  logic              rnd_up;
  logic [SUM_W-1:0]  sum_nxt;

  logic [EXP_W+FRAC_W:0] pack_z;
  logic                  pack_ovf;
  logic                  pack_inx;
  logic                  sum_ovf;

  // Stage 2 advances whenever it is empty or its result is being taken;
  // stage 1 advances whenever it is empty or drains into stage 2.
  assign load2     = ~v2 | OUT_READY;
  assign load1     = ~v1 | load2;
  assign IN_READY  = load1;
  assign OUT_VALID = v2;

  // Round-half-even increment; a fraction carry ripples into the exponent field.
  always_comb begin
    rnd_up  = IN_GRS[2] & (IN_GRS[1] | IN_GRS[0] | IN_F[0]);
    sum_nxt = {IN_E, IN_F} + SUM_W'(rnd_up);
  end

  // Stage 1 register: rounded magnitude, sign, class, inexact and saturated-exponent marker.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      v1    <= 1'b0;
      s1    <= 1'b0;
      sum1  <= '0;
      spec1 <= SPEC_NORM;
      inx1  <= 1'b0;
      emax1 <= 1'b0;
    end else if (load1) begin
      v1 <= IN_VALID;
      if (IN_VALID) begin
        s1    <= IN_S;
        sum1  <= sum_nxt;
        spec1 <= IN_SPEC;
        inx1  <= |IN_GRS;
        // An all-ones entry exponent can wrap past the sum width, so remember it explicitly.
        emax1 <= &IN_E;
      end
    end
  end

  // Pack by operand class; normals that reach the max exponent saturate to infinity.
  always_comb begin
    sum_ovf  = emax1 | (sum1[SUM_W-1:FRAC_W] == EXP_MAX);
    pack_z   = {s1, sum1};
    pack_ovf = 1'b0;
    pack_inx = 1'b0;
    case (spec1)
      SPEC_NORM: begin
        if (sum_ovf) begin
          pack_z   = {s1, EXP_MAX, {FRAC_W{1'b0}}};
          pack_ovf = 1'b1;
          pack_inx = 1'b1;
        end else begin
          pack_z   = {s1, sum1};
          pack_inx = inx1;
        end
      end
      SPEC_ZERO: pack_z = {s1, {SUM_W{1'b0}}};
      SPEC_INF:  pack_z = {s1, EXP_MAX, {FRAC_W{1'b0}}};
      default:   pack_z = QNAN_WORD;
    endcase
  end

  // Stage 2 register: holds the packed result until the consumer takes it.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      v2      <= 1'b0;
      OUT_Z   <= '0;
      OUT_OVF <= 1'b0;
      OUT_INX <= 1'b0;
    end else if (load2) begin
      v2 <= v1;
      if (v1) begin
        OUT_Z   <= pack_z;
        OUT_OVF <= pack_ovf;
        OUT_INX <= pack_inx;
      end
    end
  end

endmodule

// File: tb/tb_fpaddsub_round_module.sv
// Testbench for fpaddsub_round_module: directed rounding/special-value vectors,
// streaming with stalls, randomized traffic against an arithmetic reference model,
// and reset while beats are in flight.
module tb_fpaddsub_round_module;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        IN_VALID;
  logic        IN_READY;
  logic        IN_S;
  logic [7:0]  IN_E;
  logic [22:0] IN_F;
  logic [2:0]  IN_GRS;
  logic [1:0]  IN_SPEC;
  logic        OUT_VALID;
  logic        OUT_READY;
  logic [31:0] OUT_Z;
  logic        OUT_OVF;
  logic        OUT_INX;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic        s;
    logic [7:0]  e;
    logic [22:0] f;
    logic [2:0]  grs;
    logic [1:0]  spec;
    logic [31:0] z;
    logic        ovf;
    logic        inx;
  } vec_t;

  always #5 CLK = ~CLK;

  fpaddsub_round_module #(.EXP_W(8), .FRAC_W(23)) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .IN_VALID  (IN_VALID),
    .IN_READY  (IN_READY),
    .IN_S      (IN_S),
    .IN_E      (IN_E),
    .IN_F      (IN_F),
    .IN_GRS    (IN_GRS),
    .IN_SPEC   (IN_SPEC),
    .OUT_VALID (OUT_VALID),
    .OUT_READY (OUT_READY),
    .OUT_Z     (OUT_Z),
    .OUT_OVF   (OUT_OVF),
    .OUT_INX   (OUT_INX)
  );

  // Reference: treat {E,F} as one integer magnitude, add one ulp when rounding up,
  // and saturate to infinity once the magnitude reaches exponent 255.
  function automatic logic [33:0] model(input logic s, input logic [7:0] e, input logic [22:0] f,
                                        input logic [2:0] grs, input logic [1:0] spec);
    longint      mag;
    logic [31:0] z;
    logic        ovf;
    logic        inx;
    ovf = 1'b0;
    inx = 1'b0;
    z   = 32'h0;
    case (spec)
      2'b01: z = {s, 31'h0};
      2'b10: z = {s, 8'hFF, 23'h0};
      2'b11: z = 32'h7FC00000;
      default: begin
        mag = longint'(e) * 64'd8388608 + longint'(f);
        if (grs[2] && (grs[1] || grs[0] || f[0])) mag = mag + 1;
        inx = (grs != 3'b000);
        if (mag >= 64'd255 * 64'd8388608) begin
          z   = {s, 8'hFF, 23'h0};
          ovf = 1'b1;
          inx = 1'b1;
        end else begin
          z = {s, mag[30:0]};
        end
      end
    endcase
    return {ovf, inx, z};
  endfunction

  task automatic drive_beat(input logic s, input logic [7:0] e, input logic [22:0] f,
                            input logic [2:0] grs, input logic [1:0] spec);
    IN_VALID = 1'b1;
    IN_S     = s;
    IN_E     = e;
    IN_F     = f;
    IN_GRS   = grs;
    IN_SPEC  = spec;
  endtask

  task automatic drive_random_beat();
    int r;
    IN_VALID = 1'b1;
    IN_S     = 1'($urandom);
    r = $urandom_range(0, 7);
    IN_E     = (r == 0) ? 8'hFE : (r == 1) ? 8'hFF : (r == 2) ? 8'h00 : 8'($urandom);
    IN_F     = ($urandom_range(0, 3) == 0) ? 23'h7FFFFF : 23'($urandom);
    IN_GRS   = 3'($urandom);
    IN_SPEC  = ($urandom_range(0, 7) < 5) ? 2'b00 : 2'($urandom_range(1, 3));
  endtask

  // Sends one beat into an empty pipeline with OUT_READY high and returns the first result seen.
  task automatic run_single(input logic s, input logic [7:0] e, input logic [22:0] f,
                            input logic [2:0] grs, input logic [1:0] spec,
                            output logic [31:0] z, output logic ovf, output logic inx, output int lat);
    z   = 'x;
    ovf = 1'bx;
    inx = 1'bx;
    lat = -1;
    @(posedge CLK); #1;
    OUT_READY = 1'b1;
    drive_beat(s, e, f, grs, spec);
    @(posedge CLK); #1;
    IN_VALID = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge CLK);
      if (OUT_VALID) begin
        z   = OUT_Z;
        ovf = OUT_OVF;
        inx = OUT_INX;
        lat = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    RST_N     = 1'b0;
    IN_VALID  = 1'b0;
    OUT_READY = 1'b0;
    drive_beat(1'b0, 8'h0, 23'h0, 3'b000, 2'b00);
    IN_VALID  = 1'b0;
    #12;
    checks++;
    if (OUT_VALID !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", OUT_VALID); end
    checks++;
    if (OUT_Z !== 32'h0) begin failures++; $display("FAIL reset_out_z got=%h exp=00000000", OUT_Z); end
    checks++;
    if ({OUT_OVF, OUT_INX} !== 2'b00) begin failures++; $display("FAIL reset_flags got=%b%b exp=00", OUT_OVF, OUT_INX); end
    @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);
    checks++;
    if (IN_READY !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", IN_READY); end
  endtask

  task automatic test_basic();
    logic [31:0] z;
    logic        ovf;
    logic        inx;
    int          lat;
    run_single(1'b0, 8'h7F, 23'h0, 3'b000, 2'b00, z, ovf, inx, lat);
    checks++;
    if (lat !== 2) begin failures++; $display("FAIL basic_latency got=%0d exp=2", lat); end
    checks++;
    if ({ovf, inx, z} !== {2'b00, 32'h3F800000}) begin
      failures++; $display("FAIL basic_one got=%h ovf=%b inx=%b exp=3f800000 ovf=0 inx=0", z, ovf, inx);
    end
  endtask

  task automatic run_table(input string tag, input vec_t tbl[7], input int n);
    logic [31:0] z;
    logic        ovf;
    logic        inx;
    int          lat;
    for (int i = 0; i < n; i++) begin
      run_single(tbl[i].s, tbl[i].e, tbl[i].f, tbl[i].grs, tbl[i].spec, z, ovf, inx, lat);
      checks++;
      if ({ovf, inx, z} !== {tbl[i].ovf, tbl[i].inx, tbl[i].z}) begin
        failures++;
        $display("FAIL %s[%0d] got z=%h ovf=%b inx=%b exp z=%h ovf=%b inx=%b lat=%0d",
                 tag, i, z, ovf, inx, tbl[i].z, tbl[i].ovf, tbl[i].inx, lat);
      end
    end
  endtask

  task automatic test_rounding();
    vec_t tbl[7];
    tbl[0] = '{1'b0, 8'h7F, 23'h000001, 3'b100, 2'b00, 32'h3F800002, 1'b0, 1'b1};
    tbl[1] = '{1'b0, 8'h7F, 23'h000002, 3'b100, 2'b00, 32'h3F800002, 1'b0, 1'b1};
    tbl[2] = '{1'b0, 8'h7F, 23'h7FFFFF, 3'b110, 2'b00, 32'h40000000, 1'b0, 1'b1};
    tbl[3] = '{1'b0, 8'h7F, 23'h000002, 3'b011, 2'b00, 32'h3F800002, 1'b0, 1'b1};
    tbl[4] = '{1'b1, 8'h80, 23'h000003, 3'b100, 2'b00, 32'hC0000004, 1'b0, 1'b1};
    tbl[5] = '{1'b0, 8'h7F, 23'h000000, 3'b001, 2'b00, 32'h3F800000, 1'b0, 1'b1};
    tbl[6] = '{1'b0, 8'h7F, 23'h000004, 3'b101, 2'b00, 32'h3F800005, 1'b0, 1'b1};
    run_table("round", tbl, 7);
  endtask

  task automatic test_special();
    vec_t tbl[7];
    tbl[0] = '{1'b1, 8'hFE, 23'h7FFFFF, 3'b101, 2'b00, 32'hFF800000, 1'b1, 1'b1};
    tbl[1] = '{1'b0, 8'hFE, 23'h7FFFFF, 3'b000, 2'b00, 32'h7F7FFFFF, 1'b0, 1'b0};
    tbl[2] = '{1'b0, 8'hFF, 23'h000000, 3'b000, 2'b00, 32'h7F800000, 1'b1, 1'b1};
    tbl[3] = '{1'b1, 8'h12, 23'h000345, 3'b111, 2'b01, 32'h80000000, 1'b0, 1'b0};
    tbl[4] = '{1'b1, 8'h12, 23'h000345, 3'b111, 2'b10, 32'hFF800000, 1'b0, 1'b0};
    tbl[5] = '{1'b1, 8'h12, 23'h000345, 3'b111, 2'b11, 32'h7FC00000, 1'b0, 1'b0};
    tbl[6] = '{1'b0, 8'hFE, 23'h7FFFFF, 3'b100, 2'b00, 32'h7F800000, 1'b1, 1'b1};
    run_table("special", tbl, 7);
  endtask

  // mode 0: IN_VALID always high, OUT_READY pattern 1,0,0,1; mode 1: random valid and ready.
  task automatic test_stream(input string tag, input int n, input int mode);
    logic [33:0] q[$];
    logic [33:0] exp_v;
    logic [33:0] held;
    logic        held_vld;
    logic        acc;
    logic        exp_rdy;
    logic [3:0]  pat;
    int          sent;
    int          got;
    int          cyc;
    pat      = 4'b1001;
    sent     = 0;
    got      = 0;
    cyc      = 0;
    held_vld = 1'b0;
    held     = '0;
    acc      = 1'b0;
    IN_VALID = 1'b0;
    while (got < n && cyc < 4000) begin
      @(posedge CLK); #1;
      OUT_READY = (mode == 0) ? pat[cyc % 4] : ($urandom_range(0, 3) != 0);
      cyc++;
      if (acc || !IN_VALID) begin
        if (sent < n && (mode == 0 || $urandom_range(0, 3) != 0)) begin
          drive_random_beat();
          sent++;
        end else begin
          IN_VALID = 1'b0;
        end
      end
      @(negedge CLK);
      exp_rdy = !(q.size() == 2 && !OUT_READY);
      checks++;
      if (IN_READY !== exp_rdy) begin
        failures++; $display("FAIL %s_in_ready cyc=%0d got=%b exp=%b inflight=%0d", tag, cyc, IN_READY, exp_rdy, q.size());
      end
      if (held_vld) begin
        checks++;
        if (OUT_VALID !== 1'b1 || {OUT_OVF, OUT_INX, OUT_Z} !== held) begin
          failures++; $display("FAIL %s_stall_stable cyc=%0d got v=%b %h exp v=1 %h", tag, cyc, OUT_VALID, {OUT_OVF, OUT_INX, OUT_Z}, held);
        end
      end
      if (OUT_VALID === 1'b1 && q.size() == 0) begin
        checks++;
        failures++; $display("FAIL %s_spurious cyc=%0d got z=%h exp no output", tag, cyc, OUT_Z);
      end else if (OUT_VALID === 1'b1 && OUT_READY) begin
        exp_v = q.pop_front();
        got++;
        checks++;
        if ({OUT_OVF, OUT_INX, OUT_Z} !== exp_v) begin
          failures++; $display("FAIL %s_data beat=%0d got ovf,inx,z=%h exp=%h", tag, got, {OUT_OVF, OUT_INX, OUT_Z}, exp_v);
        end
      end
      acc = IN_VALID && IN_READY;
      if (acc) q.push_back(model(IN_S, IN_E, IN_F, IN_GRS, IN_SPEC));
      held_vld = OUT_VALID && !OUT_READY;
      held     = {OUT_OVF, OUT_INX, OUT_Z};
    end
    checks++;
    if (got != n) begin failures++; $display("FAIL %s_count got=%0d exp=%0d", tag, got, n); end
    @(posedge CLK); #1;
    IN_VALID  = 1'b0;
    OUT_READY = 1'b1;
    repeat (4) @(negedge CLK);
    checks++;
    if (OUT_VALID !== 1'b0 || q.size() != 0) begin
      failures++; $display("FAIL %s_drain got valid=%b leftover=%0d exp valid=0 leftover=0", tag, OUT_VALID, q.size());
    end
  endtask

  task automatic test_reset_inflight();
    logic [31:0] z;
    logic        ovf;
    logic        inx;
    int          lat;
    logic        seen;
    @(posedge CLK); #1;
    OUT_READY = 1'b0;
    drive_beat(1'b0, 8'h7F, 23'h000001, 3'b000, 2'b00);
    @(posedge CLK); #1;
    drive_beat(1'b0, 8'h7F, 23'h000002, 3'b000, 2'b00);
    @(posedge CLK); #1;
    IN_VALID = 1'b0;
    @(negedge CLK);
    checks++;
    if (OUT_VALID !== 1'b1 || OUT_Z !== 32'h3F800001) begin
      failures++; $display("FAIL rst_prefill got v=%b z=%h exp v=1 z=3f800001", OUT_VALID, OUT_Z);
    end
    #1 RST_N = 1'b0;
    #1;
    checks++;
    if (OUT_VALID !== 1'b0 || OUT_Z !== 32'h0) begin
      failures++; $display("FAIL rst_async got v=%b z=%h exp v=0 z=00000000", OUT_VALID, OUT_Z);
    end
    @(negedge CLK);
    RST_N     = 1'b1;
    OUT_READY = 1'b1;
    seen      = 1'b0;
    repeat (4) begin
      @(negedge CLK);
      if (OUT_VALID !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen) begin failures++; $display("FAIL rst_no_ghost got output after release exp none"); end
    run_single(1'b0, 8'h7F, 23'h000003, 3'b000, 2'b00, z, ovf, inx, lat);
    checks++;
    if (z !== 32'h3F800003 || lat !== 2) begin
      failures++; $display("FAIL rst_first_new got z=%h lat=%0d exp z=3f800003 lat=2", z, lat);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired got timeout exp completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_rounding();
    test_special();
    test_stream("b2b", 8, 0);
    test_stream("rand", 300, 1);
    test_reset_inflight();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
